stream_demux_1_2: RTL and testbench

- Buffered 1-to-2 stream demultiplexer. It is the splitting counterpart of the 2:1 select mux.
- It accepts one valid/ready request stream tagged with a select bit and stores entries in an in-order FIFO. Each head entry is steered to output channel 0 or 1.
- Used to route CPU-side requests, e.g. data memory vs. peripheral port, with backpressure. Ordering is preserved across both channels: head-of-line blocking is intentional.

---
 rtl/stream_demux_1_2.sv | 94 +++++++++
 tb/tb_stream_demux_1_2.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_2.sv
// rtl/stream_demux_1_2.sv - buffered 1-to-2 stream demultiplexer with in-order FIFO
//
// Ports:
//   clk_i, rst_ni                      clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o              upstream handshake
//   in_sel_i, in_data_i                target channel and payload of the offered entry
//   out0_valid_o/out0_ready_i/out0_data_o  channel 0 handshake and payload
//   out1_valid_o/out1_ready_i/out1_data_o  channel 1 handshake and payload
//   count_o                            number of stored entries

module stream_demux_1_2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_sel_i,
    input  logic [WIDTH-1:0]         in_data_i,
    output logic                     out0_valid_o,
    input  logic                     out0_ready_i,
    output logic [WIDTH-1:0]         out0_data_o,
    output logic                     out1_valid_o,
    input  logic                     out1_ready_i,
    output logic [WIDTH-1:0]         out1_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    // Each entry is {sel, data}; sel lives in the top bit.
    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;

    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   head;
    logic             head_sel;
    logic [WIDTH-1:0] head_data;

    assign empty      = (count == '0);
    assign in_ready_o = (count != FULL_COUNT);
    assign push       = in_valid_i && in_ready_o;

    assign head      = mem[rptr];
    assign head_sel  = head[WIDTH];
    assign head_data = head[WIDTH-1:0];

    // Valids come from registered state only, so the head cannot change
    // under a downstream that is still deciding.
    assign out0_valid_o = !empty && !head_sel;
    assign out1_valid_o = !empty &&  head_sel;

    // Data is forced to zero on the idle channel; this also hides the
    // uninitialised array contents while empty.
    assign out0_data_o = out0_valid_o ? head_data : '0;
    assign out1_data_o = out1_valid_o ? head_data : '0;

    assign pop     = (out0_valid_o && out0_ready_i) || (out1_valid_o && out1_ready_i);
    assign count_o = count;

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= {in_sel_i, in_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_demux_1_2.sv
// tb/tb_stream_demux_1_2.sv - directed self-checking bench for stream_demux_1_2

module tb_stream_demux_1_2;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] sb [$];

    always #5 clk = ~clk;

    stream_demux_1_2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_sel_i     (in_sel),
        .in_data_i    (in_data),
        .out0_valid_o (out0_valid),
        .out0_ready_i (out0_ready),
        .out0_data_o  (out0_data),
        .out1_valid_o (out1_valid),
        .out1_ready_i (out1_ready),
        .out1_data_o  (out1_data),
        .count_o      (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drains every scoreboard entry with both readys high,
    // checking one entry per cycle on the channel its sel bit names.
    task automatic drain(input string tag);
        int n;
        logic [32:0] e;
        n = sb.size();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            check({tag, "_v0"}, 64'(out0_valid), 64'(!e[32]));
            check({tag, "_v1"}, 64'(out1_valid), 64'(e[32]));
            check({tag, "_data"}, 64'(e[32] ? out1_data : out0_data), 64'(e[31:0]));
            check({tag, "_idle_data"}, 64'(e[32] ? out0_data : out1_data), 64'd0);
            @(negedge clk);
        end
        check({tag, "_empty"}, 64'(count), 64'd0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  pat;
        logic        s;
        logic [31:0] d;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_v0", 64'(out0_valid), 64'd0);
        check("rst_v1", 64'(out1_valid), 64'd0);
        check("rst_d0", 64'(out0_data), 64'd0);
        check("rst_d1", 64'(out1_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);

        // Basic routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hAAAA_0001;
        @(negedge clk);
        check("basic_count1", 64'(count), 64'd1);
        check("basic_v0", 64'(out0_valid), 64'd1);
        check("basic_v1_lo", 64'(out1_valid), 64'd0);
        check("basic_d0", 64'(out0_data), 64'hAAAA_0001);
        in_sel  = 1'b1;
        in_data = 32'hBBBB_0002;
        @(negedge clk);
        check("basic_count2", 64'(count), 64'd1);
        check("basic_v1", 64'(out1_valid), 64'd1);
        check("basic_v0_lo", 64'(out0_valid), 64'd0);
        check("basic_d1", 64'(out1_data), 64'hBBBB_0002);
        check("basic_d0_zero", 64'(out0_data), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("basic_count3", 64'(count), 64'd0);
        check("basic_v1_end", 64'(out1_valid), 64'd0);

        // Fill / full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = (i % 2 == 0);
            in_data  = 32'h100 + 32'(i);
            sb.push_back({in_sel, in_data});
            @(negedge clk);
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_sel  = 1'b1;
        in_data = 32'h105;
        @(negedge clk);
        check("full_hold_count", 64'(count), 64'd4);
        check("full_hold_ready", 64'(in_ready), 64'd0);
        check("full_head_v1", 64'(out1_valid), 64'd1);
        check("full_head_d1", 64'(out1_data), 64'h100);
        out1_ready = 1'b1;
        @(negedge clk);
        void'(sb.pop_front());
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        out1_ready = 1'b0;
        @(negedge clk);
        sb.push_back({1'b1, 32'h105});
        check("full_refill_count", 64'(count), 64'd4);
        in_valid = 1'b0;
        drain("full");

        // Head-of-line blocking, repeated so the pointers wrap
        pat = 4'b0110;
        for (int rep = 0; rep < 3; rep++) begin
            out0_ready = 1'b0;
            out1_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_sel   = pat[i];
                in_data  = 32'hD000_0000 + 32'(rep * 16 + i);
                sb.push_back({in_sel, in_data});
                @(negedge clk);
                check("hol_no_v1", 64'(out1_valid), 64'd0);
            end
            in_valid = 1'b0;
            check("hol_count", 64'(count), 64'd4);
            check("hol_v0", 64'(out0_valid), 64'd1);
            drain("hol");
        end

        // Simultaneous push/pop streaming
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s = 1'($urandom_range(0, 1));
            d = $urandom;
            in_valid = 1'b1;
            in_sel   = s;
            in_data  = d;
            @(negedge clk);
            check("stream_count", 64'(count), 64'd1);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_v0", 64'(out0_valid), 64'(!s));
            check("stream_v1", 64'(out1_valid), 64'(s));
            check("stream_data", 64'(s ? out1_data : out0_data), 64'(d));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_end_count", 64'(count), 64'd0);

        // Reset mid-operation
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'(i);
            in_data  = 32'hE000_0000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_count3", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_v0", 64'(out0_valid), 64'd0);
        check("mid_rst_v1", 64'(out1_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_d0", 64'(out0_data), 64'd0);
        check("mid_rst_d1", 64'(out1_data), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hC0DE_0001;
        sb.push_back({1'b1, 32'hC0DE_0001});
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_count", 64'(count), 64'd1);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
